// File: rtl/sctr_wb.sv
// sctr_wb: write-back/stall sequencing for loads, stores, divide and trap entry,
// plus the core's bus master port with a posted write buffer and error capture.
module sctr_wb #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int WBUF_DEPTH = 2,
  parameter int TMO_CYC    = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_en_i,
  input  logic            mem_we_i,
  input  logic [AW-1:0]   mem_addr_i,
  input  logic [DW-1:0]   mem_wdata_i,
  input  logic [DW/8-1:0] mem_wem_i,
  output logic [DW-1:0]   mem_rdata_o,
  input  logic            div_start_i,
  input  logic            div_ready_i,
  input  logic            iram_rstn_i,
  input  logic            trap_in_i,
  input  logic            trap_jump_i,
  input  logic            idex_mret_i,
  output logic            hx_valid,
  output logic            reg_we_o,
  output logic            csr_we_o,
  output logic            iram_rd_o,
  output logic            trap_stat_o,
  output logic [DW-1:0]   sctr_cmd_wdata,
  output logic [AW-1:0]   sctr_cmd_addr,
  output logic            sctr_cmd_we,
  output logic [DW/8-1:0] sctr_cmd_wem,
  output logic            sctr_cmd_valid,
  input  logic            sctr_cmd_ready,
  input  logic [DW-1:0]   sctr_rsp_rdata,
  input  logic            sctr_rsp_error,
  input  logic            sctr_rsp_valid,
  output logic            sctr_rsp_ready,
  output logic            bus_err_o,
  output logic [1:0]      bus_err_code_o,
  output logic            bus_err_we_o,
  output logic [AW-1:0]   bus_err_addr_o,
  output logic            wbuf_empty_o
);
  localparam int IW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int PW = $clog2(WBUF_DEPTH) + 1;
  localparam int CW = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
  localparam int MW = DW / 8;

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_DIV_WAIT} state_e;
  state_e state_q;

  logic [AW-1:0] buf_addr [2**IW];
  logic [DW-1:0] buf_data [2**IW];
  logic [MW-1:0] buf_wem  [2**IW];

  logic [PW-1:0] wp_q, ip_q, rp_q, count;
  logic [CW-1:0] tmo_q;
  logic [AW-1:0] rd_addr_q, err_addr_q;
  logic [1:0]    err_code_q;
  logic          discard_q, trap_stat_q, err_q, err_we_q;

  logic idle, st_req, ld_req, full, idle_ok, push, wr_issue, ld_issue;
  logic rsp_rd, rsp_wr, rsp_drop, timeout, rd_trap, rd_leave;

  assign count = wp_q - rp_q;

  always_comb begin
    idle     = (state_q == S_IDLE);
    st_req   = mem_en_i & mem_we_i;
    ld_req   = mem_en_i & ~mem_we_i;
    full     = (count == PW'(WBUF_DEPTH));
    idle_ok  = ~div_start_i & ~iram_rstn_i & ~trap_in_i;
    push     = idle & idle_ok & st_req & ~full;
    // A stale read response must drain before anything else goes on the bus.
    wr_issue = (ip_q != wp_q) & ~discard_q;
    ld_issue = idle & idle_ok & ld_req & (count == '0) & ~discard_q;
    rsp_drop = sctr_rsp_valid & discard_q;
    rsp_rd   = sctr_rsp_valid & ~discard_q & (state_q == S_RD_WAIT);
    rsp_wr   = sctr_rsp_valid & ~discard_q & (state_q != S_RD_WAIT) & (rp_q != ip_q);
    timeout  = (TMO_CYC != 0) && (state_q == S_RD_WAIT) && !sctr_rsp_valid
               && ((int'(tmo_q) + 1) == TMO_CYC);
    rd_trap  = (state_q == S_RD_WAIT) & ~sctr_rsp_valid & ~timeout & trap_in_i;
    rd_leave = rsp_rd | timeout | rd_trap;
  end

  always_comb begin
    sctr_cmd_valid = wr_issue | ld_issue;
    sctr_cmd_addr  = '0;
    sctr_cmd_wdata = '0;
    sctr_cmd_wem   = '0;
    sctr_cmd_we    = 1'b0;
    if (wr_issue) begin
      sctr_cmd_addr  = buf_addr[ip_q[IW-1:0]];
      sctr_cmd_wdata = buf_data[ip_q[IW-1:0]];
      sctr_cmd_wem   = buf_wem[ip_q[IW-1:0]];
      sctr_cmd_we    = 1'b1;
    end else if (ld_issue) begin
      sctr_cmd_addr  = mem_addr_i;
    end
  end

  always_comb begin
    hx_valid = 1'b0;
    case (state_q)
      S_IDLE:     hx_valid = idle_ok & ~ld_req & ~(st_req & full);
      S_RD_WAIT:  hx_valid = rsp_rd | timeout;
      S_DIV_WAIT: hx_valid = div_ready_i & ~trap_in_i;
      default:    hx_valid = 1'b0;
    endcase
  end

  assign mem_rdata_o    = rsp_rd ? sctr_rsp_rdata : '0;
  assign reg_we_o       = hx_valid;
  assign csr_we_o       = hx_valid;
  assign iram_rd_o      = hx_valid | trap_jump_i;
  assign trap_stat_o    = trap_stat_q;
  assign sctr_rsp_ready = 1'b1;
  assign bus_err_o      = err_q;
  assign bus_err_code_o = err_code_q;
  assign bus_err_we_o   = err_we_q;
  assign bus_err_addr_o = err_addr_q;
  assign wbuf_empty_o   = (count == '0);

  // Buffer storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wp_q[IW-1:0]] <= mem_addr_i;
      buf_data[wp_q[IW-1:0]] <= mem_wdata_i;
      buf_wem[wp_q[IW-1:0]]  <= mem_wem_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wp_q        <= '0;
      ip_q        <= '0;
      rp_q        <= '0;
      tmo_q       <= '0;
      rd_addr_q   <= '0;
      discard_q   <= 1'b0;
      trap_stat_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      err_we_q    <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      err_q <= 1'b0;
      if (push) wp_q <= wp_q + PW'(1);
      if (wr_issue & sctr_cmd_ready) ip_q <= ip_q + PW'(1);
      if (rsp_wr) rp_q <= rp_q + PW'(1);
      if (rsp_drop) discard_q <= 1'b0;
      if (timeout | rd_trap) discard_q <= 1'b1;

      if (trap_jump_i) trap_stat_q <= 1'b1;
      else if (idex_mret_i & hx_valid) trap_stat_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (ld_issue & sctr_cmd_ready) begin
            state_q   <= S_RD_WAIT;
            rd_addr_q <= mem_addr_i;
          end else if (div_start_i & ~trap_in_i) begin
            state_q <= S_DIV_WAIT;
          end
        end
        S_RD_WAIT:  if (rd_leave) state_q <= S_IDLE;
        S_DIV_WAIT: if (div_ready_i | trap_in_i) state_q <= S_IDLE;
        default:    state_q <= S_IDLE;
      endcase
      tmo_q <= ((state_q == S_RD_WAIT) && !rd_leave) ? tmo_q + CW'(1) : '0;

      if (rsp_wr & sctr_rsp_error) begin
        err_q      <= 1'b1;
        err_code_q <= 2'b01;
        err_we_q   <= 1'b1;
        err_addr_q <= buf_addr[rp_q[IW-1:0]];
      end else if ((rsp_rd & sctr_rsp_error) | timeout) begin
        err_q      <= 1'b1;
        err_code_q <= timeout ? 2'b10 : 2'b01;
        err_we_q   <= 1'b0;
        err_addr_q <= rd_addr_q;
      end
    end
  end
endmodule

// File: tb/tb_sctr_wb.sv
// tb_sctr_wb: directed scenarios plus random load/store traffic, checked against a
// program-order memory model and an in-order bus responder with its own memory.
`timescale 1ns/1ps
module tb_sctr_wb;
  localparam int DW = 32, AW = 32, DEPTH = 2, TMO = 4;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic        mem_en_i = 0, mem_we_i = 0;
  logic [31:0] mem_addr_i = 0, mem_wdata_i = 0;
  logic [3:0]  mem_wem_i = 0;
  logic        div_start_i = 0, div_ready_i = 0, iram_rstn_i = 0;
  logic        trap_in_i = 0, trap_jump_i = 0, idex_mret_i = 0;
  logic        sctr_cmd_ready = 0, sctr_rsp_valid = 0, sctr_rsp_error = 0;
  logic [31:0] sctr_rsp_rdata = 0;
  logic [31:0] mem_rdata_o, sctr_cmd_wdata, sctr_cmd_addr, bus_err_addr_o;
  logic [3:0]  sctr_cmd_wem;
  logic [1:0]  bus_err_code_o;
  logic        hx_valid, reg_we_o, csr_we_o, iram_rd_o, trap_stat_o, sctr_cmd_we;
  logic        sctr_cmd_valid, sctr_rsp_ready, bus_err_o, bus_err_we_o, wbuf_empty_o;

  sctr_wb #(.DW(DW), .AW(AW), .WBUF_DEPTH(DEPTH), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .mem_en_i(mem_en_i), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_wem_i(mem_wem_i),
    .mem_rdata_o(mem_rdata_o), .div_start_i(div_start_i), .div_ready_i(div_ready_i),
    .iram_rstn_i(iram_rstn_i), .trap_in_i(trap_in_i), .trap_jump_i(trap_jump_i),
    .idex_mret_i(idex_mret_i), .hx_valid(hx_valid), .reg_we_o(reg_we_o),
    .csr_we_o(csr_we_o), .iram_rd_o(iram_rd_o), .trap_stat_o(trap_stat_o),
    .sctr_cmd_wdata(sctr_cmd_wdata), .sctr_cmd_addr(sctr_cmd_addr),
    .sctr_cmd_we(sctr_cmd_we), .sctr_cmd_wem(sctr_cmd_wem),
    .sctr_cmd_valid(sctr_cmd_valid), .sctr_cmd_ready(sctr_cmd_ready),
    .sctr_rsp_rdata(sctr_rsp_rdata), .sctr_rsp_error(sctr_rsp_error),
    .sctr_rsp_valid(sctr_rsp_valid), .sctr_rsp_ready(sctr_rsp_ready),
    .bus_err_o(bus_err_o), .bus_err_code_o(bus_err_code_o),
    .bus_err_we_o(bus_err_we_o), .bus_err_addr_o(bus_err_addr_o),
    .wbuf_empty_o(wbuf_empty_o)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] rdata; logic err; int due; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] wem; } st_t;

  rsp_t        pend[$];                  // commands accepted by the bus, awaiting response
  st_t         exp_st[$];                // completed stores not yet seen on the bus
  logic [31:0] bmem [logic [31:0]];      // bus-side memory
  logic [31:0] rmem [logic [31:0]];      // program-order reference memory

  int n_chk = 0, n_pass = 0;
  int cyc = 0, pushed = 0, st_rsp = 0, err_cnt = 0;
  int ld_acc_cyc = 0, rd_rsp_cyc = 0, st_acc_cyc = 0, hold = 0, lat_force = 0;
  bit rdy_rand = 1, err_next = 0;

  logic        s_hx, s_err, s_ewe, s_cmdv, s_iram, s_tstat, s_empty, s_rdacc;
  logic [31:0] s_rd, s_eaddr;
  logic [1:0]  s_code;
  int          s_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] rmem_rd(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : dflt(a);
  endfunction

  // One clock: sample at negedge, run the bus responder, drive the next cycle at posedge+1.
  task automatic tick();
    rsp_t e;
    st_t  s;
    @(negedge clk);
    s_cyc = cyc; s_hx = hx_valid; s_rd = mem_rdata_o; s_err = bus_err_o;
    s_code = bus_err_code_o; s_eaddr = bus_err_addr_o; s_ewe = bus_err_we_o;
    s_cmdv = sctr_cmd_valid; s_iram = iram_rd_o; s_tstat = trap_stat_o;
    s_empty = wbuf_empty_o; s_rdacc = 0;
    if (s_err) err_cnt++;
    if (!sctr_cmd_valid)
      chk("idle_bus", {sctr_cmd_addr, sctr_cmd_wdata} | 64'({sctr_cmd_we, sctr_cmd_wem}), 64'd0);
    if (!rst && sctr_cmd_valid && sctr_cmd_ready) begin
      e.we = sctr_cmd_we; e.addr = sctr_cmd_addr; e.err = err_next; err_next = 0;
      e.due = cyc + ((lat_force > 0) ? lat_force : int'($urandom_range(1, 3)));
      if (sctr_cmd_we) begin
        chk("st_pending", 64'(exp_st.size() > 0), 64'd1);
        if (exp_st.size() > 0) begin
          s = exp_st.pop_front();
          chk("st_addr", 64'(sctr_cmd_addr), 64'(s.addr));
          chk("st_data", 64'(sctr_cmd_wdata), 64'(s.data));
          chk("st_wem", 64'(sctr_cmd_wem), 64'(s.wem));
        end
        bmem[sctr_cmd_addr] = merge(bmem_rd(sctr_cmd_addr), sctr_cmd_wdata, sctr_cmd_wem);
        e.rdata = $urandom;
        st_acc_cyc = cyc;
      end else begin
        chk("ld_order", 64'(pend.size() == 0 && pushed == st_rsp), 64'd1);
        e.rdata = bmem_rd(sctr_cmd_addr);
        ld_acc_cyc = cyc;
        s_rdacc = 1;
      end
      pend.push_back(e);
    end
    if (!rst && sctr_rsp_valid && pend.size() > 0) begin
      e = pend.pop_front();
      if (e.we) st_rsp++;
      else rd_rsp_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (hold > 0) begin
      sctr_cmd_ready = 0;
      hold--;
    end else begin
      sctr_cmd_ready = rdy_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      sctr_rsp_valid = 1; sctr_rsp_rdata = pend[0].rdata; sctr_rsp_error = pend[0].err;
    end else begin
      sctr_rsp_valid = 0; sctr_rsp_rdata = 0; sctr_rsp_error = 0;
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          output int waited);
    st_t s;
    bit  done, room;
    done = 0; waited = 0;
    mem_en_i = 1; mem_we_i = 1; mem_addr_i = a; mem_wdata_i = d; mem_wem_i = m;
    while (!done && waited < 50) begin
      room = (pushed - st_rsp) < DEPTH;
      tick();
      chk("st_hx", 64'(s_hx), 64'(room));
      if (s_hx) done = 1;
      else waited++;
    end
    mem_en_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_wdata_i = 0; mem_wem_i = 0;
    chk("st_done", 64'(done), 64'd1);
    if (done) begin
      pushed++;
      rmem[a] = merge(rmem_rd(a), d, m);
      s.addr = a; s.data = d; s.wem = m;
      exp_st.push_back(s);
    end
    $display("txn store addr=%08h data=%08h wem=%h stall=%0d", a, d, m, waited);
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] got, output int hx_cyc);
    int n;
    bit done;
    n = 0; done = 0;
    mem_en_i = 1; mem_we_i = 0; mem_addr_i = a;
    while (!done && n < 60) begin
      tick();
      n++;
      if (s_hx) done = 1;
    end
    mem_en_i = 0; mem_addr_i = 0;
    chk("ld_done", 64'(done), 64'd1);
    got = s_rd; hx_cyc = s_cyc;
    $display("txn load  addr=%08h data=%08h cycles=%0d", a, got, n);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(wbuf_empty_o && pend.size() == 0) && n < 100) begin
      tick();
      n++;
    end
    chk("drain", 64'(wbuf_empty_o && pend.size() == 0), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int w1, w2, w3, hc, e0;
    logic [31:0] got, a, d;
    bmem[32'h200] = 32'hDEADBEEF;
    rmem[32'h200] = 32'hDEADBEEF;
    repeat (3) tick();
    rst = 0;
    tick();
    chk("rst_hx", 64'(s_hx), 64'd1);
    chk("rst_cmdv", 64'(s_cmdv), 64'd0);
    chk("rst_tstat", 64'(s_tstat), 64'd0);
    chk("rst_err", {s_eaddr, 29'd0, s_code, s_err}, 64'd0);
    chk("rst_ewe", 64'(s_ewe), 64'd0);
    chk("rst_empty", 64'(s_empty), 64'd1);

    // Three back-to-back stores with the bus stalled for five cycles.
    rdy_rand = 0; hold = 5;
    do_store(32'h10, 32'h1111_1111, 4'hF, w1);
    do_store(32'h14, 32'h2222_2222, 4'hF, w2);
    do_store(32'h18, 32'h3333_3333, 4'hF, w3);
    chk("tp_st1_wait", 64'(w1), 64'd0);
    chk("tp_st2_wait", 64'(w2), 64'd0);
    chk("tp_st3_stall", 64'(w3 >= 5), 64'd1);
    drain();

    // Store then load: load waits for the store, completes in the response cycle.
    lat_force = 1;
    do_store(32'h100, 32'hCAFE_0100, 4'hF, w1);
    do_load(32'h200, got, hc);
    lat_force = 0;
    chk("tp_ld_data", 64'(got), 64'hDEADBEEF);
    chk("tp_ld_lat", 64'(hc - ld_acc_cyc), 64'd1);

    // Load with an error response: write-back still happens, error reported next cycle.
    err_next = 1;
    do_load(32'h200, got, hc);
    chk("lderr_data", 64'(got), 64'hDEADBEEF);
    tick();
    chk("lderr_pulse", 64'(s_err), 64'd1);
    chk("lderr_code", 64'(s_code), 64'd1);
    chk("lderr_addr", 64'(s_eaddr), 64'h200);
    chk("lderr_we", 64'(s_ewe), 64'd0);
    tick();
    chk("lderr_once", 64'(s_err), 64'd0);
    chk("lderr_hold", 64'(s_eaddr), 64'h200);

    // Store with an error response.
    drain();
    err_next = 1;
    do_store(32'h300, 32'hBAD0_0300, 4'h3, w1);
    for (int i = 0; i < 20 && !s_err; i++) tick();
    chk("sterr_pulse", 64'(s_err), 64'd1);
    chk("sterr_code", 64'(s_code), 64'd1);
    chk("sterr_we", 64'(s_ewe), 64'd1);
    chk("sterr_addr", 64'(s_eaddr), 64'h300);
    drain();

    // Timeout: no response within TMO cycles; the late response is dropped silently.
    lat_force = 12;
    do_load(32'h240, got, hc);
    lat_force = 0;
    chk("tmo_data", 64'(got), 64'd0);
    chk("tmo_lat", 64'(hc - ld_acc_cyc), 64'(TMO));
    tick();
    chk("tmo_pulse", 64'(s_err), 64'd1);
    chk("tmo_code", 64'(s_code), 64'd2);
    chk("tmo_addr", 64'(s_eaddr), 64'h240);
    e0 = err_cnt;
    do_load(32'h200, got, hc);
    chk("tmo_next_data", 64'(got), 64'hDEADBEEF);
    chk("tmo_late_silent", 64'(err_cnt), 64'(e0));

    // Trap during RD_WAIT: no write-back, a following store waits for the stale response.
    drain();
    lat_force = 8;
    mem_en_i = 1; mem_we_i = 0; mem_addr_i = 32'h200;
    w1 = 0;
    do begin tick(); w1++; end while (!s_rdacc && w1 < 20);
    chk("tr_acc", 64'(s_rdacc), 64'd1);
    mem_en_i = 0; mem_addr_i = 0; lat_force = 0;
    trap_in_i = 1;
    tick();
    chk("tr_hx", 64'(s_hx), 64'd0);
    trap_in_i = 0;
    e0 = err_cnt;
    do_store(32'h380, 32'h1234_5678, 4'hF, w1);
    drain();
    chk("tr_st_after_stale", 64'(st_acc_cyc > rd_rsp_cyc), 64'd1);
    chk("tr_silent", 64'(err_cnt), 64'(e0));
    do_load(32'h380, got, hc);
    chk("tr_ld_data", 64'(got), 64'h1234_5678);

    // Trap status.
    trap_in_i = 1; trap_jump_i = 1;
    tick();
    chk("tj_iram", 64'(s_iram), 64'd1);
    chk("tj_hx", 64'(s_hx), 64'd0);
    trap_in_i = 0; trap_jump_i = 0;
    tick();
    chk("tstat_set", 64'(s_tstat), 64'd1);
    iram_rstn_i = 1; idex_mret_i = 1;
    tick();
    chk("iram_stall_hx", 64'(s_hx), 64'd0);
    iram_rstn_i = 0;
    tick();
    chk("tstat_hold", 64'(s_tstat), 64'd1);
    chk("mret_hx", 64'(s_hx), 64'd1);
    idex_mret_i = 0;
    tick();
    chk("tstat_clr", 64'(s_tstat), 64'd0);

    // Divide sequencing.
    div_start_i = 1; tick(); chk("div_start_hx", 64'(s_hx), 64'd0);
    div_start_i = 0; tick(); chk("div_wait_hx", 64'(s_hx), 64'd0);
    div_ready_i = 1; tick(); chk("div_done_hx", 64'(s_hx), 64'd1);
    div_ready_i = 0; tick(); chk("div_idle_hx", 64'(s_hx), 64'd1);

    // Random traffic over a small address window.
    rdy_rand = 1;
    for (int i = 0; i < 150; i++) begin
      a = 32'h400 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 2) != 0) begin
        d = $urandom;
        do_store(a, d, 4'($urandom_range(1, 15)), w1);
      end else begin
        do_load(a, got, hc);
        chk("rnd_ld_data", 64'(got), 64'(rmem_rd(a)));
      end
    end
    drain();

    // Reset with stores still buffered drops them.
    rdy_rand = 0; hold = 20;
    do_store(32'h500, 32'h5, 4'hF, w1);
    do_store(32'h504, 32'h6, 4'hF, w1);
    rst = 1;
    tick();
    rst = 0;
    pend.delete(); exp_st.delete(); pushed = 0; st_rsp = 0; hold = 0;
    tick();
    chk("rst_mid_empty", 64'(s_empty), 64'd1);
    chk("rst_mid_cmdv", 64'(s_cmdv), 64'd0);
    tick();
    chk("rst_mid_cmdv2", 64'(s_cmdv), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
